// File: rtl/cam_pkg.sv
// Shared definitions for the CAM host driver: FSM state encoding and the
// pin-format constants of the CAM slice on the TinyTapeout pins.
//   CAM_SEL   : ui_in[7:6] value that selects the CAM
//   WR_BIT    : ui_in bit carrying the write strobe
//   FOUND_BIT : uo_out bit carrying the match flag
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0]  CAM_SEL   = 2'b11;
    localparam int unsigned WR_BIT    = 5;
    localparam int unsigned FOUND_BIT = 4;

    // Idle pin image: CAM selected, search, address 0.
    localparam logic [7:0]  UI_RESET  = {CAM_SEL, 6'b00_0000};

endpackage

// File: rtl/cam_lat_counter.sv
// Load/decrement counter with a zero flag, used to time the uo_out sample.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one
//   zero       : count is zero
module cam_lat_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cam_host_driver.sv
// Host-side initiator for the CAM slice of tt_um_top. Turns a valid/ready
// request stream into pin-level commands on ui_in/uio_in, samples uo_out a
// fixed latency later and returns search results on a valid/ready stream.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_write/req_addr/req_data: 1=write data at addr, 0=search data
//   rsp_valid/rsp_ready        : search-result handshake (no response to writes)
//   rsp_found/rsp_addr         : match flag and address (0 when not found)
//   ena_o/ui_in_o/uio_in_o     : pins driven into the DUT
//   uo_out_i                   : DUT result pins
module cam_host_driver
    import cam_pkg::*;
#(
    parameter int unsigned RSP_LAT = 2,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_found,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              ena_o,
    output logic [7:0]        ui_in_o,
    output logic [7:0]        uio_in_o,
    input  logic [7:0]        uo_out_i
);

    if (ADDR_W > 4 || DATA_W != 8 || RSP_LAT < 1) begin : g_bad_params
        $error("cam_host_driver: requires ADDR_W<=4, DATA_W==8, RSP_LAT>=1");
    end

    localparam int unsigned      CNT_W    = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RSP_LAT - 1);

    state_t state;
    logic   is_write;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // Counter is loaded on the launch edge so WAIT lasts RSP_LAT cycles.
    assign cnt_load = (state == LAUNCH);
    assign cnt_dec  = (state == WAIT) && !cnt_zero;

    cam_lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_found <= 1'b0;
            rsp_addr  <= '0;
            ena_o     <= 1'b1;
            ui_in_o   <= UI_RESET;
            uio_in_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_write  <= req_write;
                        ui_in_o   <= {CAM_SEL, req_write, 1'b0, 4'(req_addr)};
                        uio_in_o  <= req_data;
                        req_ready <= 1'b0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // DUT has sampled the command on this edge; drop the write
                    // strobe immediately so it sees exactly one write cycle.
                    ui_in_o[WR_BIT] <= 1'b0;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
                        if (is_write) begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rsp_found <= uo_out_i[FOUND_BIT];
                            rsp_addr  <= uo_out_i[FOUND_BIT] ? uo_out_i[ADDR_W-1:0] : '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_host_driver.sv
module tb_cam_host_driver;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_found;
    logic [3:0] rsp_addr;
    logic       ena_o;
    logic [7:0] ui_in_o;
    logic [7:0] uio_in_o;
    logic [7:0] uo_out_i;

    int checks   = 0;
    int failures = 0;

    logic [4:0] sb[$];

    // Reference contents for expected results.
    logic [7:0] ref_mem[16];
    bit         ref_v[16];

    // Behavioural CAM slice on the far side of the pins.
    logic [7:0] cam_mem[16];
    bit         cam_v[16];

    cam_host_driver #(
        .RSP_LAT (2),
        .ADDR_W  (4),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_found (rsp_found),
        .rsp_addr  (rsp_addr),
        .ena_o     (ena_o),
        .ui_in_o   (ui_in_o),
        .uio_in_o  (uio_in_o),
        .uo_out_i  (uo_out_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Miss responses carry junk on the address bits so address masking is exercised.
    always @(posedge clk) begin
        if (ena_o && ui_in_o[7:6] == 2'b11) begin
            if (ui_in_o[5]) begin
                cam_mem[ui_in_o[3:0]] <= uio_in_o;
                cam_v[ui_in_o[3:0]]   <= 1'b1;
            end else begin
                logic [7:0] r;
                r = 8'hAA;
                for (int i = 15; i >= 0; i--) begin
                    if (cam_v[i] && cam_mem[i] == uio_in_o) r = {3'b000, 1'b1, 4'(i)};
                end
                uo_out_i <= r;
            end
        end
    end

    function automatic logic [4:0] exp_res(input logic [7:0] d);
        for (int i = 0; i < 16; i++) begin
            if (ref_v[i] && ref_mem[i] == d) return {1'b1, 4'(i)};
        end
        return 5'b0_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, req_ready, 1);
    endtask

    task automatic send(input logic w, input logic [3:0] a, input logic [7:0] d);
        wait_ready("idle_ready");
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("launch_ui", ui_in_o, {2'b11, w, 1'b0, a});
        chk("launch_uio", uio_in_o, d);
        chk("launch_busy", req_ready, 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        bit saw = 0;
        send(1'b1, a, d);
        ref_mem[a] = d;
        ref_v[a]   = 1'b1;
        @(negedge clk);
        chk("wr_bit_clear", ui_in_o[5], 0);
        while (!req_ready && n < 50) begin
            if (rsp_valid) saw = 1;
            @(negedge clk);
            n++;
        end
        if (rsp_valid) saw = 1;
        chk("wr_no_rsp", saw, 0);
        chk("wr_done", req_ready, 1);
    endtask

    task automatic get_rsp(input string tag);
        int n = 0;
        logic [4:0] e;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        e = (sb.size() != 0) ? sb.pop_front() : 5'h1F;
        chk(tag, {rsp_found, rsp_addr}, e);
    endtask

    task automatic do_search(input string tag, input logic [7:0] d);
        sb.push_back(exp_res(d));
        send(1'b0, 4'h0, d);
        get_rsp(tag);
        @(negedge clk);
        chk({tag, "_done_valid"}, rsp_valid, 0);
        chk({tag, "_done_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] held;
        for (int i = 0; i < 16; i++) begin
            cam_v[i]   = 1'b0;
            cam_mem[i] = 8'h00;
            ref_v[i]   = 1'b0;
            ref_mem[i] = 8'h00;
        end
        uo_out_i  = 8'h00;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_found", rsp_found, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_ui", ui_in_o, 8'hC0);
        chk("rst_uio", uio_in_o, 8'h00);
        chk("rst_ena", ena_o, 1);
        rst_n = 1'b1;
        @(negedge clk);

        do_write(4'd0, 8'h55);
        do_search("srch_55_first", 8'h55);

        do_write(4'd1, 8'hAA);
        do_write(4'd2, 8'h77);
        do_write(4'd15, 8'h33);
        do_search("srch_55", 8'h55);
        do_search("srch_AA", 8'hAA);
        do_search("srch_77", 8'h77);
        do_search("srch_33", 8'h33);
        do_search("srch_FF_miss", 8'hFF);

        do_write(4'd1, 8'hCC);
        do_search("srch_AA_gone", 8'hAA);
        do_search("srch_CC", 8'hCC);

        // Response backpressure.
        rsp_ready = 1'b0;
        sb.push_back(exp_res(8'h77));
        send(1'b0, 4'h0, 8'h77);
        get_rsp("bp_first");
        held = {rsp_found, rsp_addr};
        chk("bp_value", held, 5'b1_0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", rsp_valid, 1);
            chk("bp_data_hold", {rsp_found, rsp_addr}, held);
            chk("bp_req_busy", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", req_ready, 1);

        // Reset during WAIT aborts the search.
        send(1'b0, 4'h0, 8'h55);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ui", ui_in_o, 8'hC0);
        chk("abort_uio", uio_in_o, 8'h00);
        chk("abort_ready", req_ready, 1);
        chk("abort_valid", rsp_valid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_no_rsp", rsp_valid, 0);
        do_search("srch_after_abort", 8'h55);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
